// File: rtl/dma_mem_responder.sv
// dma_mem_responder: arbitrates a single RAM port between ANTIC DMA fetches and CPU accesses.
// DMA (halt_L low) always wins over a CPU access that has not started yet. The CPU is held
// through RDY_L while DMA owns the bus. A DMA fetch with no mem_ack is aborted after MAX_WAIT cycles.
// Ports: phi2/RST are the clock and the async reset. halt_L and address form the ANTIC request.
// cpu_* is the CPU request/response. mem_* is the RAM port. DB_out/DB_oe drive the ANTIC data bus.
// RDY_L halts the CPU. dma_err and dma_count report DMA status.
module dma_mem_responder #(
  parameter int MAX_WAIT = 8
) (
  input  logic        phi2,
  input  logic        RST,
  input  logic        halt_L,
  input  logic [15:0] address,
  input  logic        cpu_req,
  input  logic        cpu_RW,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic        mem_en,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic [7:0]  DB_out,
  output logic        DB_oe,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_rdy,
  output logic        RDY_L,
  output logic        dma_err,
  output logic [15:0] dma_count
);

  typedef enum logic [1:0] {IDLE, CPU_ACC, DMA_ACC, DMA_HOLD} state_t;

  localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  // Value the wait counter holds during the last permitted DMA_ACC cycle.
  localparam logic [WW-1:0] WAIT_LAST = WW'(MAX_WAIT - 1);

  state_t        state;
  logic [WW-1:0] wait_cnt;

  always_ff @(posedge phi2 or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 8'h00;
      DB_out    <= 8'h00;
      DB_oe     <= 1'b0;
      cpu_rdata <= 8'h00;
      cpu_rdy   <= 1'b0;
      dma_err   <= 1'b0;
      dma_count <= 16'h0000;
      wait_cnt  <= '0;
    end else begin
      // cpu_rdy and dma_err are single-cycle pulses.
      cpu_rdy <= 1'b0;
      dma_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!halt_L) begin
            state    <= DMA_ACC;
            mem_addr <= address;
            mem_en   <= 1'b1;
            mem_we   <= 1'b0;
            wait_cnt <= '0;
          end else if (cpu_req) begin
            state     <= CPU_ACC;
            mem_addr  <= cpu_addr;
            mem_wdata <= cpu_wdata;
            mem_we    <= ~cpu_RW;
            mem_en    <= 1'b1;
          end
        end
        CPU_ACC: begin
          // No timeout here. A halt_L falling edge waits for this access to finish.
          if (mem_ack) begin
            mem_en  <= 1'b0;
            mem_we  <= 1'b0;
            cpu_rdy <= 1'b1;
            // The registered direction is used, so a late change on cpu_RW cannot corrupt a write.
            if (!mem_we) cpu_rdata <= mem_rdata;
            state <= IDLE;
          end
        end
        DMA_ACC: begin
          // An ack in the final wait cycle is checked first, so real data wins over the timeout.
          if (mem_ack) begin
            DB_out    <= mem_rdata;
            DB_oe     <= 1'b1;
            mem_en    <= 1'b0;
            dma_count <= dma_count + 16'd1;
            state     <= DMA_HOLD;
          end else if (wait_cnt == WAIT_LAST) begin
            DB_out    <= 8'hFF;
            DB_oe     <= 1'b1;
            dma_err   <= 1'b1;
            mem_en    <= 1'b0;
            dma_count <= dma_count + 16'd1;
            state     <= DMA_HOLD;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        DMA_HOLD: begin
          DB_oe <= 1'b0;
          if (!halt_L) begin
            // Back-to-back fetch. IDLE is skipped, so ANTIC loses no cycle.
            state    <= DMA_ACC;
            mem_addr <= address;
            mem_en   <= 1'b1;
            mem_we   <= 1'b0;
            wait_cnt <= '0;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // This path is combinational from halt_L, so the CPU stops in the same cycle that ANTIC asks.
  assign RDY_L = halt_L && (state != DMA_ACC) && (state != DMA_HOLD);

endmodule

// File: doc/dma_mem_responder.md
DMA_MEM_RESPONDER -- requirements
Module: dma_mem_responder

Interface
REQ-001 Parameter MAX_WAIT, default 8, is the number of cycles a DMA fetch waits for mem_ack before it is aborted.
REQ-002 phi2  input  1  single system clock; all state changes on posedge phi2.
REQ-003 RST  input  1  asynchronous, active-high reset.
REQ-004 halt_L  input  1  DMA request from ANTIC, active-low.
REQ-005 address  input  16  DMA fetch address from ANTIC, sampled on DMA grant.
REQ-006 cpu_req  input  1  CPU access request, level, held until cpu_rdy.
REQ-007 cpu_RW  input  1  CPU direction: 1 = read, 0 = write.
REQ-008 cpu_addr  input  16  CPU access address.
REQ-009 cpu_wdata  input  8  CPU write data.
REQ-010 mem_rdata  input  8  RAM read data, valid while mem_ack=1.
REQ-011 mem_ack  input  1  RAM completion strobe, one cycle.
REQ-012 mem_en  output  1  RAM access strobe, held until mem_ack or abort.
REQ-013 mem_we  output  1  RAM write enable, valid with mem_en.
REQ-014 mem_addr  output  16  RAM address.
REQ-015 mem_wdata  output  8  RAM write data.
REQ-016 DB_out  output  8  byte returned to ANTIC DB.
REQ-017 DB_oe  output  1  DB_out drive enable toward ANTIC.
REQ-018 cpu_rdata  output  8  CPU read data.
REQ-019 cpu_rdy  output  1  one-cycle CPU completion pulse.
REQ-020 RDY_L  output  1  CPU halt, active-low; 0 while DMA owns the bus.
REQ-021 dma_err  output  1  one-cycle pulse on DMA timeout.
REQ-022 dma_count  output  16  completed DMA bytes, incl. timeouts.

Function
REQ-023 FSM states: IDLE, CPU_ACC, DMA_ACC, DMA_HOLD.
REQ-024 In IDLE, halt_L=0 wins over cpu_req: next state DMA_ACC; mem_addr<=address, mem_en<=1, mem_we<=0, wait counter cleared.
REQ-025 In IDLE with halt_L=1 and cpu_req=1: next state CPU_ACC; mem_addr<=cpu_addr, mem_wdata<=cpu_wdata, mem_we<=~cpu_RW, mem_en<=1.
REQ-026 In DMA_ACC, on mem_ack: DB_out<=mem_rdata, DB_oe<=1, mem_en<=0, dma_count+1, next state DMA_HOLD.
REQ-027 In DMA_ACC, the wait counter increments each cycle without mem_ack; at MAX_WAIT cycles: DB_out<=8'hFF, DB_oe<=1, dma_err pulses, mem_en<=0, dma_count+1, next state DMA_HOLD.
REQ-028 mem_ack in the same cycle as the timeout takes precedence; data is used and dma_err stays 0.
REQ-029 DMA_HOLD lasts one cycle with DB_oe=1, then DB_oe<=0.
REQ-030 Leaving DMA_HOLD: halt_L=0 gives back-to-back fetch (DMA_ACC, new address latched); otherwise IDLE.
REQ-031 In CPU_ACC, on mem_ack: mem_en<=0, cpu_rdy pulses one cycle, cpu_rdata<=mem_rdata on reads (unchanged on writes), next state IDLE.
REQ-032 halt_L falling during CPU_ACC does not abort the CPU access; DMA starts from IDLE on the following cycle.
REQ-033 CPU accesses have no timeout.
REQ-034 RDY_L = 0 combinationally whenever halt_L=0 or state is DMA_ACC or DMA_HOLD; otherwise 1.
REQ-035 dma_count wraps FFFF->0000.
REQ-036 mem_ack arriving in IDLE or DMA_HOLD is ignored.

Reset
REQ-037 RST=1 asynchronously forces: state IDLE; mem_en, mem_we, DB_oe, cpu_rdy, dma_err = 0; RDY_L = 1 unless halt_L=0; DB_out = 8'h00; cpu_rdata = 8'h00; mem_addr and mem_wdata = 0; dma_count = 0; wait counter = 0.
REQ-038 RST asserted mid-access abandons the access with no cpu_rdy or dma_err pulse; operation resumes from IDLE on the first clock after release.

Verification
REQ-039 halt_L=0, address=16'h0230, mem_ack 2 cycles later with mem_rdata=8'h3C -> mem_addr=0230, DB_out=3C, DB_oe high for exactly 1 cycle, dma_count=1, RDY_L=0 throughout.
REQ-040 halt_L=0 and cpu_req=1 (read, 16'h1000) in the same IDLE cycle -> DMA served first; CPU read served after halt_L=1; cpu_rdy pulses once.
REQ-041 halt_L held low for 3 fetches at addresses 16'h0400/0401/0402 -> three DB_oe pulses; no IDLE cycles between fetches; dma_count=3.
REQ-042 DMA with no mem_ack -> after 8 cycles DB_out=FF and dma_err pulses once; in a second run with mem_ack in cycle 8, data is used and dma_err=0.
REQ-043 CPU write 8'hA5 to 16'h02F4 with halt_L falling mid-access -> mem_we=1 and write completes with cpu_rdy; DMA starts 1 cycle later.
REQ-044 RST pulsed during DMA_ACC -> all outputs at reset values immediately; no dma_err; next halt_L=0 fetch behaves normally.
